// File: rtl/sha3_msg_loader_if.sv
// ---------------------------------------------------------------------------
// sha3_msg_loader_if
//   Bundles the two handshakes around the SHA3 message loader.
//
//   Word stream (into the loader):
//     in_data   [63:0]  message word, byte k at bits [8k+7:8k]
//     in_valid          word present
//     in_last           final word of the message
//     in_bytes  [3:0]   valid bytes in the final word (0..8, larger clamps)
//     in_ready          loader accepts a word this cycle
//   Block stream (out of the loader):
//     blk_data  [RATE_WORDS*64-1:0]  rate block, lane i at [64i+63:64i]
//     blk_valid         block presented and held stable
//     blk_last          block is the final padded block
//     blk_ready         downstream accepts the block
//     blk_cnt   [15:0]  blocks of the current message handed off so far
//                       (present only when SHA3_MSG_LOADER_BLKCNT_EN is defined)
//
//   Modports: slave  = the loader's view
//             master = the surrounding environment's view
// ---------------------------------------------------------------------------
interface sha3_msg_loader_if #(
    parameter int unsigned RATE_WORDS = 17
);
    logic [63:0]              in_data;
    logic                     in_valid;
    logic                     in_last;
    logic [3:0]               in_bytes;
    logic                     in_ready;
    logic [RATE_WORDS*64-1:0] blk_data;
    logic                     blk_valid;
    logic                     blk_last;
    logic                     blk_ready;
`ifdef SHA3_MSG_LOADER_BLKCNT_EN
    logic [15:0]              blk_cnt;
`endif

    modport slave (
        input  in_data, in_valid, in_last, in_bytes, blk_ready,
        output in_ready, blk_data, blk_valid, blk_last
`ifdef SHA3_MSG_LOADER_BLKCNT_EN
        , output blk_cnt
`endif
    );

    modport master (
        output in_data, in_valid, in_last, in_bytes, blk_ready,
        input  in_ready, blk_data, blk_valid, blk_last
`ifdef SHA3_MSG_LOADER_BLKCNT_EN
        , input blk_cnt
`endif
    );
endinterface

// File: rtl/sha3_msg_loader.sv
// ---------------------------------------------------------------------------
// sha3_msg_loader
//   Front end of the SHA3-256 core. Packs 64-bit little-endian message words
//   into RATE_WORDS-lane rate blocks, applies pad10*1 with DOMAIN_BYTE as the
//   first padding byte, and hands each block downstream flagged with
//   blk_last on the final one. Downstream never pads.
//
//   Ports:
//     clk   single clock, all state on the rising edge
//     rst   asynchronous, active-low reset
//     bus   sha3_msg_loader_if.slave (word stream in, block stream out)
//
//   Optional feature: define SHA3_MSG_LOADER_BLKCNT_EN to add bus.blk_cnt,
//   a saturating count of blocks handed off for the current message.
// ---------------------------------------------------------------------------
module sha3_msg_loader #(
    parameter int unsigned RATE_WORDS  = 17,
    parameter logic [7:0]  DOMAIN_BYTE = 8'h06
) (
    input  logic             clk,
    input  logic             rst,
    sha3_msg_loader_if.slave bus
);
    localparam int unsigned      BLK_W    = RATE_WORDS * 64;
    localparam int unsigned      IDX_W    = $clog2(RATE_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_WORDS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    // Final 1 bit of pad10*1 sits in the top byte of the block.
    localparam logic [BLK_W-1:0] PAD_END  = {8'h80, {(BLK_W-8){1'b0}}};
    localparam logic [BLK_W-1:0] PAD_ONLY = PAD_END | {{(BLK_W-8){1'b0}}, DOMAIN_BYTE};

    typedef enum logic {FILL, OUT} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] widx_reg, widx_next;
    logic [BLK_W-1:0] buf_reg, buf_next;
    logic             last_reg, last_next;
    logic             pend_reg, pend_next;

    logic [3:0]       n_clamp;
    logic [63:0]      lane_word;
    logic [IDX_W+5:0] lane_lsb;
    logic [IDX_W+5:0] next_lsb;
    logic             word_xfer;
    logic             blk_xfer;

    assign n_clamp   = (bus.in_bytes > 4'd8) ? 4'd8 : bus.in_bytes;
    assign lane_lsb  = {widx_reg, 6'd0};
    assign next_lsb  = {widx_reg + ONE_IDX, 6'd0};
    assign word_xfer = bus.in_valid && (state_reg == FILL);
    assign blk_xfer  = bus.blk_ready && (state_reg == OUT);

    // Final-word lane: keep bytes below n, put the domain byte at n, zero the
    // rest. With n=8 no byte matches, so the domain byte spills to the next lane.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane_byte
        assign lane_word[8*gi +: 8] =
            (4'(gi) < n_clamp)  ? bus.in_data[8*gi +: 8] :
            (4'(gi) == n_clamp) ? DOMAIN_BYTE : 8'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= FILL;
            widx_reg  <= '0;
            buf_reg   <= '0;
            last_reg  <= 1'b0;
            pend_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            widx_reg  <= widx_next;
            buf_reg   <= buf_next;
            last_reg  <= last_next;
            pend_reg  <= pend_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        widx_next  = widx_reg;
        buf_next   = buf_reg;
        last_next  = last_reg;
        pend_next  = pend_reg;
        unique case (state_reg)
            FILL: begin
                if (word_xfer) begin
                    if (!bus.in_last) begin
                        buf_next[lane_lsb +: 64] = bus.in_data;
                        if (widx_reg == LAST_IDX) begin
                            state_next = OUT;
                            last_next  = 1'b0;
                        end else begin
                            widx_next = widx_reg + ONE_IDX;
                        end
                    end else begin
                        buf_next[lane_lsb +: 64] = lane_word;
                        state_next = OUT;
                        if (n_clamp != 4'd8) begin
                            // XOR so the domain and end bytes merge to 0x86
                            // when both land on the top byte.
                            buf_next  = buf_next ^ PAD_END;
                            last_next = 1'b1;
                        end else if (widx_reg != LAST_IDX) begin
                            buf_next[next_lsb +: 8] = DOMAIN_BYTE;
                            buf_next  = buf_next ^ PAD_END;
                            last_next = 1'b1;
                        end else begin
                            // Full block of data: padding needs a block of its own.
                            last_next = 1'b0;
                            pend_next = 1'b1;
                        end
                    end
                end
            end
            OUT: begin
                if (blk_xfer) begin
                    if (pend_reg) begin
                        buf_next  = PAD_ONLY;
                        last_next = 1'b1;
                        pend_next = 1'b0;
                    end else begin
                        buf_next   = '0;
                        widx_next  = '0;
                        last_next  = 1'b0;
                        state_next = FILL;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs come straight from registers, so blk_ready never reaches in_ready
    // combinationally; the price is one bubble cycle after each handshake.
    assign bus.in_ready  = (state_reg == FILL);
    assign bus.blk_valid = (state_reg == OUT);
    assign bus.blk_data  = buf_reg;
    assign bus.blk_last  = last_reg;

`ifdef SHA3_MSG_LOADER_BLKCNT_EN
    logic [15:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (blk_xfer) begin
            if (last_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg != 16'hFFFF) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    assign bus.blk_cnt = cnt_reg;
`endif
endmodule
